riscv_core_amo_ctrl: RTL
========================

// Module: riscv_core_amo_ctrl
// PURPOSE
//  Sequencer for RV64A atomics between the memory stage and the data-memory port.
//  Runs AMO<op>.W/.D as a locked read-modify-write through riscv_core_amo_alu.
//  Runs LR/SC against a single reservation register.
//  Returns the original memory value (AMO/LR) or the SC status to the core for rd writeback.
// PARAMETERS
//  DATA_WIDTH  64  data/address width (XLEN)
// PORTS
//  i_clk            in   1           core clock; all state updates on rising edge
//  i_rst            in   1           synchronous reset, active-high
//  i_amo_valid      in   1           atomic request; sampled only in IDLE
//  i_amo_op         in   4           AMO ALU op code (0 SWAP .. 8 MINU); ignored for LR/SC
//  i_amo_lr         in   1           request is LR (exclusive of i_amo_sc)
//  i_amo_sc         in   1           request is SC
//  i_amo_word       in   1           1 = .W (32-bit), 0 = .D
//  i_amo_addr       in   DATA_WIDTH  effective address (naturally aligned, checked upstream)
//  i_amo_wdata      in   DATA_WIDTH  rs2 value
//  o_amo_busy       out  1           high in every state except IDLE; core stalls
//  o_amo_done       out  1           one-cycle pulse, result valid
//  o_amo_rd_data    out  DATA_WIDTH  rd value; held until next request
//  o_mem_req        out  1           memory request; held until i_mem_ack
//  o_mem_we         out  1           1 = write
//  o_mem_word       out  1           access size, 1 = 32-bit
//  o_mem_addr       out  DATA_WIDTH  request address
//  o_mem_wdata      out  DATA_WIDTH  write data, right-aligned
//  i_mem_ack        in   1           request accepted/completed this cycle; read data valid
//  i_mem_rdata      in   DATA_WIDTH  read data, right-aligned
//  i_resv_clear     in   1           external invalidate: trap, xRET, snoop
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; reservation invalid.
//  FSM: IDLE -> RD -> (SC ? WR : LR ? DONE : WR) -> DONE -> IDLE.
//   IDLE: when i_amo_valid, latch op/flags/addr/wdata and assert busy next cycle.
//     SC with an invalid reservation, or an address mismatch, goes straight to DONE with rd = 1.
//     That SC makes no memory access.
//   RD: o_mem_req=1, we=0 until i_mem_ack.
//     Latch i_mem_rdata; when word, sign-extend bit 31 to DATA_WIDTH.
//   LR: after RD, set reservation {valid=1, addr=latched addr & ~7}.
//   WR: o_mem_req=1, we=1 until i_mem_ack.
//     Write data is ALU result for AMO, rs2 for SC; for .W only the low 32 bits are meaningful.
//   DONE: o_amo_done=1 for one cycle.
//     rd = loaded value for AMO/LR, 0 for successful SC.
//     Every SC (pass or fail) clears the reservation. Return to IDLE.
//  ALU feed: mem operand = sign-extended loaded value; core operand = rs2 sign-extended when word.
//    The sign-extension keeps signed and unsigned MIN/MAX correct for .W.
//  Req-to-ack latency: unbounded; request signals stay stable while waiting.
//  Ack-to-next-phase: 1 cycle, registered.
//  Minimum AMO latency: IDLE -> RD(ack same cycle) -> WR(ack) -> DONE = 4 cycles from valid to done.
//  i_amo_valid while busy is ignored.
//  i_resv_clear has priority over an LR set in the same cycle; the reservation ends invalid.
//  A pending SC is already committed and is not affected by i_resv_clear.
//  i_rst mid-transaction: return to IDLE and drop o_mem_req next edge; no done pulse.
//  Invalid i_amo_op (>8) as AMO: ALU returns 0, which is written; no trap here (decoded upstream).
// STRUCTURE
//  riscv_core_pkg: amo_state_e {IDLE,RD,WR,DONE}; amo_op_e codes 0..8; RESV_ALIGN_MASK.
//  One sub-module: riscv_core_amo_alu u_amo_alu (combinational); FSM and reservation live here.
// TESTING
//  AMOADD.D addr 0x80, mem 5, rs2 3, ack after 2 cycles
//    -> write 8 to 0x80; rd 5; done once.
//  AMOMAXU.W mem 0xFFFF_FFFF, rs2 1
//    -> write 0xFFFF_FFFF; rd 0xFFFF_FFFF_FFFF_FFFF.
//  AMOMIN.W same values as the AMOMAXU.W case
//    -> write 0xFFFF_FFFF (-1).
//  LR.D 0x100 then SC.D 0x100 rs2 0xAB
//    -> LR rd = mem, SC writes 0xAB, rd 0.
//    Second SC -> no mem_req, rd 1.
//  LR 0x100, pulse i_resv_clear, SC 0x100
//    -> no mem_req, rd 1.
//  LR 0x100, SC 0x108
//    -> fail, rd 1.
//  i_rst asserted in WR with ack withheld
//    -> next cycle mem_req=0, busy=0, no done.
//    A new AMOSWAP then completes normally.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared types for the RV64A atomic sequencer.
// FSM states, AMO ALU op codes and reservation granule mask.
package riscv_core_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      DONE
   } amo_state_e;

   typedef enum logic [3:0] {
      AMO_SWAP = 4'd0,
      AMO_ADD  = 4'd1,
      AMO_XOR  = 4'd2,
      AMO_AND  = 4'd3,
      AMO_OR   = 4'd4,
      AMO_MIN  = 4'd5,
      AMO_MAX  = 4'd6,
      AMO_MAXU = 4'd7,
      AMO_MINU = 4'd8
   } amo_op_e;

   // Reservation granule is one doubleword
   localparam logic [63:0] RESV_ALIGN_MASK = ~64'h7;

endpackage

// File: rtl/riscv_core_amo_ctrl_if.sv
// Core-side atomic request and data-memory port bundle.
// slave = atomic sequencer view, master = core/memory view.
interface riscv_core_amo_ctrl_if #(
   parameter int DATA_WIDTH = 64
);

   logic                  i_amo_valid;
   logic [3:0]            i_amo_op;
   logic                  i_amo_lr;
   logic                  i_amo_sc;
   logic                  i_amo_word;
   logic [DATA_WIDTH-1:0] i_amo_addr;
   logic [DATA_WIDTH-1:0] i_amo_wdata;
   logic                  o_amo_busy;
   logic                  o_amo_done;
   logic [DATA_WIDTH-1:0] o_amo_rd_data;
   logic                  o_mem_req;
   logic                  o_mem_we;
   logic                  o_mem_word;
   logic [DATA_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic                  i_mem_ack;
   logic [DATA_WIDTH-1:0] i_mem_rdata;
   logic                  i_resv_clear;

   modport slave (
      input  i_amo_valid, i_amo_op, i_amo_lr, i_amo_sc,
      input  i_amo_word, i_amo_addr, i_amo_wdata,
      output o_amo_busy, o_amo_done, o_amo_rd_data,
      output o_mem_req, o_mem_we, o_mem_word,
      output o_mem_addr, o_mem_wdata,
      input  i_mem_ack, i_mem_rdata, i_resv_clear
   );

   modport master (
      output i_amo_valid, i_amo_op, i_amo_lr, i_amo_sc,
      output i_amo_word, i_amo_addr, i_amo_wdata,
      input  o_amo_busy, o_amo_done, o_amo_rd_data,
      input  o_mem_req, o_mem_we, o_mem_word,
      input  o_mem_addr, o_mem_wdata,
      output i_mem_ack, i_mem_rdata, i_resv_clear
   );

endinterface

// File: rtl/riscv_core_amo_alu.sv
// Combinational AMO ALU: new memory value from loaded value and rs2.
// Operands arrive sign-extended for .W so MIN/MAX(U) need no size input.
module riscv_core_amo_alu
   import riscv_core_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [3:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_mem,
   input  logic [DATA_WIDTH-1:0] i_core,
   output logic [DATA_WIDTH-1:0] o_res
);

   logic lt_s;
   logic lt_u;

   assign lt_s = $signed(i_mem) < $signed(i_core);
   assign lt_u = i_mem < i_core;

   always_comb begin
      o_res = '0;
      case (i_op)
         AMO_SWAP: o_res = i_core;
         AMO_ADD:  o_res = i_mem + i_core;
         AMO_XOR:  o_res = i_mem ^ i_core;
         AMO_AND:  o_res = i_mem & i_core;
         AMO_OR:   o_res = i_mem | i_core;
         AMO_MIN:  o_res = lt_s ? i_mem : i_core;
         AMO_MAX:  o_res = lt_s ? i_core : i_mem;
         AMO_MAXU: o_res = lt_u ? i_core : i_mem;
         AMO_MINU: o_res = lt_u ? i_mem : i_core;
         default:  o_res = '0;
      endcase
   end

endmodule

// File: rtl/riscv_core_amo_ctrl.sv
// RV64A sequencer: locked AMO read-modify-write and LR/SC with
// a single reservation, between memory stage and data-memory port.
module riscv_core_amo_ctrl
   import riscv_core_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   riscv_core_amo_ctrl_if.slave  bus
);

   localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'(RESV_ALIGN_MASK);

   amo_state_e            state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic                  lr_q, lr_d;
   logic                  sc_q, sc_d;
   logic                  word_q, word_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] ld_q, ld_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic                  resv_vld_q, resv_vld_d;
   logic [DATA_WIDTH-1:0] resv_addr_q, resv_addr_d;

   logic [DATA_WIDTH-1:0] ld_ext;
   logic [DATA_WIDTH-1:0] core_op;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  resv_hit;

   function automatic logic [DATA_WIDTH-1:0] sext_w(input logic [31:0] v);
      sext_w = {{(DATA_WIDTH-32){v[31]}}, v};
   endfunction

   assign ld_ext   = word_q ? sext_w(bus.i_mem_rdata[31:0]) : bus.i_mem_rdata;
   assign core_op  = word_q ? sext_w(wdata_q[31:0]) : wdata_q;
   assign resv_hit = resv_vld_q && (resv_addr_q == (bus.i_amo_addr & MASK));

   riscv_core_amo_alu #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_amo_alu (
      .i_op   (op_q),
      .i_mem  (ld_q),
      .i_core (core_op),
      .o_res  (alu_res)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lr_d        = lr_q;
      sc_d        = sc_q;
      word_d      = word_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ld_d        = ld_q;
      rd_d        = rd_q;
      resv_vld_d  = resv_vld_q;
      resv_addr_d = resv_addr_q;

      bus.o_amo_busy    = (state_q != IDLE);
      bus.o_amo_done    = 1'b0;
      bus.o_amo_rd_data = rd_q;
      bus.o_mem_req     = 1'b0;
      bus.o_mem_we      = 1'b0;
      bus.o_mem_word    = 1'b0;
      bus.o_mem_addr    = '0;
      bus.o_mem_wdata   = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.i_amo_valid) begin
               op_d    = bus.i_amo_op;
               lr_d    = bus.i_amo_lr;
               sc_d    = bus.i_amo_sc;
               word_d  = bus.i_amo_word;
               addr_d  = bus.i_amo_addr;
               wdata_d = bus.i_amo_wdata;
               // SC outcome is decided here and never revisited
               if (bus.i_amo_sc && !resv_hit) begin
                  rd_d    = DATA_WIDTH'(1);
                  state_d = DONE;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            bus.o_mem_req  = 1'b1;
            bus.o_mem_word = word_q;
            bus.o_mem_addr = addr_q;
            if (bus.i_mem_ack) begin
               ld_d = ld_ext;
               if (lr_q) begin
                  rd_d        = ld_ext;
                  resv_vld_d  = 1'b1;
                  resv_addr_d = addr_q & MASK;
                  state_d     = DONE;
               end else begin
                  state_d = WR;
               end
            end
         end
         WR: begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_we    = 1'b1;
            bus.o_mem_word  = word_q;
            bus.o_mem_addr  = addr_q;
            bus.o_mem_wdata = sc_q ? wdata_q : alu_res;
            if (bus.i_mem_ack) begin
               rd_d    = sc_q ? '0 : ld_q;
               state_d = DONE;
            end
         end
         DONE: begin
            bus.o_amo_done = 1'b1;
            if (sc_q) resv_vld_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      if (bus.i_resv_clear) resv_vld_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         lr_q        <= 1'b0;
         sc_q        <= 1'b0;
         word_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ld_q        <= '0;
         rd_q        <= '0;
         resv_vld_q  <= 1'b0;
         resv_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lr_q        <= lr_d;
         sc_q        <= sc_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ld_q        <= ld_d;
         rd_q        <= rd_d;
         resv_vld_q  <= resv_vld_d;
         resv_addr_q <= resv_addr_d;
      end
   end

endmodule
